// File: rtl/display_digit_scanner.sv
// Time-multiplexed 7-segment digit scanner with anti-ghost blanking, leading-zero
// suppression and a frame-synchronous shadow register for tear-free value updates.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | first BLANK_CYCLES of a digit slot, all anodes inactive
//   ST_DRIVE | rest of the slot, current digit's anode may be active
module display_digit_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int REFRESH_HZ    = 4000,
    parameter int BLANK_CYCLES  = 64,
    parameter int ANODE_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    output logic [3:0]              hex_nibble,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int SLOT_CYCLES = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int TW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] SLOT_LAST  = TW'(SLOT_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_T    = TW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACT_LOW != 0}};

    if (SLOT_CYCLES <= BLANK_CYCLES || NUM_DIGITS < 2) begin : g_param_check
        $error("display_digit_scanner: need SLOT_CYCLES > BLANK_CYCLES and NUM_DIGITS >= 2");
    end

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                  state, state_nxt;
    logic [TW-1:0]           tick_cnt, tick_nxt;
    logic [IW-1:0]           digit_idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic [4*NUM_DIGITS-1:0] disp, disp_nxt;
    logic                    pending, pending_nxt;
    logic [3:0]              hex_nxt;
    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic                    slot_end, wrap;
    logic                    upper_zero, lz_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            tick_cnt    <= '0;
            digit_idx   <= '0;
            shadow      <= '0;
            disp        <= '0;
            pending     <= 1'b0;
            hex_nibble  <= 4'h0;
            anode       <= ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_nxt;
            digit_idx   <= idx_nxt;
            shadow      <= shadow_nxt;
            disp        <= disp_nxt;
            pending     <= pending_nxt;
            hex_nibble  <= hex_nxt;
            anode       <= anode_nxt;
            frame_start <= wrap;
        end
    end

    always_comb begin
        slot_end = (tick_cnt == SLOT_LAST);
        wrap     = slot_end && (digit_idx == LAST_DIGIT);
        tick_nxt = slot_end ? '0 : tick_cnt + 1'b1;
        idx_nxt  = digit_idx;
        if (slot_end) begin
            idx_nxt = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
        end
        // State tracks the tick count it will be paired with next cycle.
        state_nxt = (tick_nxt < BLANK_T) ? ST_BLANK : ST_DRIVE;

        shadow_nxt  = shadow;
        disp_nxt    = disp;
        pending_nxt = pending;
        if (value_load) begin
            shadow_nxt = value_in;
            if (wrap) begin
                disp_nxt    = value_in;
                pending_nxt = 1'b0;
            end else begin
                pending_nxt = 1'b1;
            end
        end else if (wrap && pending) begin
            disp_nxt    = shadow;
            pending_nxt = 1'b0;
        end
    end

    // Digit i is a leading zero when nibbles i..top are all zero; digit 0 never is.
    always_comb begin
        upper_zero = 1'b1;
        lz_hit     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (disp[4*i +: 4] == 4'h0);
            if (digit_idx == IW'(i)) begin
                lz_hit = upper_zero;
            end
        end
    end

    always_comb begin
        hex_nxt   = disp[4*digit_idx +: 4];
        anode_nxt = ANODE_OFF;
        if (state == ST_DRIVE && digit_en[digit_idx] && !(lz_suppress && lz_hit)) begin
            anode_nxt[digit_idx] = ~ANODE_OFF[digit_idx];
        end
    end

endmodule
